spike_classifier: RTL and testbench

Synchronous readout stage directly downstream of the spiking `network` block. Consumes the asynchronous 4-phase `req_out`/`ack_out` spike handshakes of the output layer, counts spikes per output neuron over a fixed observation window, and reports the winning class. Every handshake always completes, even when spikes are not being counted, so the network never stalls.

---
 rtl/spike_classifier_if.sv | 27 ++
 rtl/spike_classifier.sv | 122 ++++++++++++
 tb/tb_spike_classifier.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spike_classifier_if.sv
// Bundles the spike handshake channels and the classification control/result signals.
// master = upstream driver (network + controller), slave = spike_classifier.
interface spike_classifier_if #(
    parameter int unsigned neurons_out = 2,
    parameter int unsigned cnt_w       = 8
);
    localparam int unsigned cls_w = (neurons_out > 1) ? $clog2(neurons_out) : 1;

    logic [neurons_out-1:0] req_in;
    logic [neurons_out-1:0] ack_in;
    logic                   start;
    logic                   busy;
    logic                   valid;
    logic [cls_w-1:0]       class_out;
    logic [cnt_w-1:0]       win_count;
    logic                   tie;

    modport master (
        output req_in, start,
        input  ack_in, busy, valid, class_out, win_count, tie
    );

    modport slave (
        input  req_in, start,
        output ack_in, busy, valid, class_out, win_count, tie
    );
endinterface

// File: rtl/spike_classifier.sv
// Spike-count readout: acknowledges every 4-phase spike handshake and reports the winning neuron per window.
// Define SPIKE_CLASSIFIER_SAT_EN to make the per-neuron counters saturate instead of wrapping.
module spike_classifier #(
    parameter int unsigned neurons_out   = 2,
    parameter int unsigned cnt_w         = 8,
    parameter int unsigned window_cycles = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_classifier_if.slave    bus
);
    localparam int unsigned cls_w = (neurons_out > 1) ? $clog2(neurons_out) : 1;
    localparam int unsigned tmr_w = (window_cycles > 1) ? $clog2(window_cycles) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]             state;
    logic [tmr_w-1:0]       timer;
    logic [neurons_out-1:0] req_s1, req_s2, ack, ev;
    logic [cnt_w-1:0]       cnt [neurons_out];

    logic                   valid_r, tie_r;
    logic [cls_w-1:0]       cls_r;
    logic [cnt_w-1:0]       wc_r;

    logic [cls_w-1:0]       best_idx;
    logic [cnt_w-1:0]       best_cnt;
    logic                   best_tie;

    // Handshake path runs regardless of FSM state so the network never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_s1 <= '0;
            req_s2 <= '0;
            ack    <= '0;
        end else begin
            req_s1 <= bus.req_in;
            req_s2 <= req_s1;
            ack    <= req_s2;
        end
    end

    assign ev         = req_s2 & ~ack;
    assign bus.ack_in = ack;

    // A later strictly-greater count clears any tie seen against an earlier, smaller maximum.
    always_comb begin
        best_idx = '0;
        best_cnt = cnt[0];
        best_tie = 1'b0;
        for (int unsigned i = 1; i < neurons_out; i++) begin
            if (cnt[i] > best_cnt) begin
                best_cnt = cnt[i];
                best_idx = cls_w'(i);
                best_tie = 1'b0;
            end else if (cnt[i] == best_cnt) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            valid_r <= 1'b0;
            cls_r   <= '0;
            wc_r    <= '0;
            tie_r   <= 1'b0;
            for (int unsigned i = 0; i < neurons_out; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_COUNT;
                        timer <= tmr_w'(window_cycles - 1);
                        for (int unsigned i = 0; i < neurons_out; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
                S_COUNT: begin
                    for (int unsigned i = 0; i < neurons_out; i++) begin
`ifdef SPIKE_CLASSIFIER_SAT_EN
                        if (ev[i] && (cnt[i] != '1)) begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
`else
                        if (ev[i]) begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
`endif
                    end
                    if (timer == '0) begin
                        state <= S_DONE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DONE: begin
                    cls_r   <= best_idx;
                    wc_r    <= best_cnt;
                    tie_r   <= best_tie;
                    valid_r <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.valid     = valid_r;
    assign bus.class_out = cls_r;
    assign bus.win_count = wc_r;
    assign bus.tie       = tie_r;
endmodule

// File: tb/tb_spike_classifier.sv
// Scoreboard bench for spike_classifier: a window-level reference model predicts results and ack/busy behaviour.
`timescale 1ns/1ps
module tb_spike_classifier;
    localparam int unsigned NO  = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned WIN = 100;
    localparam int CMAX = 1 << CW;

    typedef struct {
        int edge_n;
        int cls;
        int cnt;
        int tie;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    spike_classifier_if #(.neurons_out(NO), .cnt_w(CW)) bus ();

    spike_classifier #(.neurons_out(NO), .cnt_w(CW), .window_cycles(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    res_t q[$];
    int k = 0;
    int last_rst = -10;
    logic [NO-1:0] rh [int];
    logic [NO-1:0] ack_m = '0, ack_prev = '0, rise;
    bit win_on = 0;
    int s_edge = 0;
    int mcnt [NO];
    bit busy_m = 0;
    bit rst_now = 0;
    int h_cls = 0, h_cnt = 0, h_tie = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, k);
        end
    endtask

    function automatic res_t judge(input int e);
        res_t r;
        int mx = 0;
        int nmx = 0;
        r.edge_n = e;
        r.cls = -1;
        foreach (mcnt[i]) if (mcnt[i] > mx) mx = mcnt[i];
        foreach (mcnt[i]) begin
            if (mcnt[i] == mx) begin
                nmx++;
                if (r.cls < 0) r.cls = i;
            end
        end
        r.cnt = mx;
        r.tie = (nmx > 1) ? 1 : 0;
        return r;
    endfunction

    // Reference model: ack follows req two edges late unless reset intervened; a window
    // counts ack rising edges at edges S+1..S+WIN and reports one edge later.
    always @(posedge clk) begin
        k++;
        rh[k] = bus.req_in;
        rst_now = rst;
        if (rst) last_rst = k;
        ack_prev = ack_m;
        ack_m = (k >= 3 && last_rst < k - 2) ? rh[k-2] : '0;
        rise = ack_m & ~ack_prev;
        if (rst) begin
            win_on = 0;
        end else if (win_on) begin
            if (k >= s_edge + 1 && k <= s_edge + int'(WIN)) begin
                for (int i = 0; i < int'(NO); i++) begin
                    if (rise[i]) begin
`ifdef SPIKE_CLASSIFIER_SAT_EN
                        if (mcnt[i] < CMAX - 1) mcnt[i]++;
`else
                        mcnt[i] = (mcnt[i] + 1) % CMAX;
`endif
                    end
                end
            end
            if (k == s_edge + int'(WIN)) q.push_back(judge(k + 1));
            if (k == s_edge + int'(WIN) + 1) win_on = 0;
        end else if (bus.start) begin
            win_on = 1;
            s_edge = k;
            foreach (mcnt[i]) mcnt[i] = 0;
        end
        busy_m = win_on;
    end

    always @(posedge clk) begin
        res_t e;
        #1;
        if (rst_now) begin
            q.delete();
            h_cls = 0;
            h_cnt = 0;
            h_tie = 0;
        end
        if (bus.valid) begin
            if (q.size() == 0) begin
                chk("valid_unexpected", int'(bus.valid), 0);
            end else begin
                e = q.pop_front();
                chk("valid_edge", k, e.edge_n);
                h_cls = e.cls;
                h_cnt = e.cnt;
                h_tie = e.tie;
            end
        end else if (q.size() > 0 && q[0].edge_n <= k) begin
            e = q.pop_front();
            chk("valid_missing", int'(bus.valid), 1);
        end
        chk("ack_in", int'(bus.ack_in), int'(ack_m));
        chk("busy", int'(bus.busy), int'(busy_m));
        chk("class_out", int'(bus.class_out), h_cls);
        chk("win_count", int'(bus.win_count), h_cnt);
        chk("tie", int'(bus.tie), h_tie);
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spikes(input int n0, input int n1);
        int m;
        m = (n0 > n1) ? n0 : n1;
        for (int i = 0; i < m; i++) begin
            @(negedge clk);
            bus.req_in = {(i < n1), (i < n0)};
            @(negedge clk);
            @(negedge clk);
            bus.req_in = '0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((win_on || q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("window_timeout", (win_on || q.size() != 0) ? 1 : 0, 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at edge %0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.req_in = '0;
        bus.start  = 1'b0;
        rst = 1'b1;
        cyc_n(3);
        rst = 1'b0;
        cyc_n(2);

        pulse_start(); cyc_n(1); spikes(5, 2); wait_idle();
        pulse_start(); spikes(3, 3); wait_idle();

        spikes(2, 2); cyc_n(4);
        pulse_start(); wait_idle();

        // ch1 lands on the final counting edge, ch0 on the DONE edge
        pulse_start(); s = k;
        while (k < s + int'(WIN) - 3) @(negedge clk);
        bus.req_in = 2'b10; @(negedge clk);
        bus.req_in = 2'b11; @(negedge clk);
        bus.req_in = 2'b01; @(negedge clk);
        bus.req_in = 2'b00;
        wait_idle();

        pulse_start(); cyc_n(1); spikes(2, 20); wait_idle();

        pulse_start(); cyc_n(5); spikes(2, 1);
        @(negedge clk); bus.req_in = 2'b01;
        cyc_n(20);
        rst = 1'b1; cyc_n(1); rst = 1'b0;
        cyc_n(6); bus.req_in = '0; cyc_n(6);
        pulse_start(); spikes(1, 2); wait_idle();

        pulse_start(); s = k;
        cyc_n(10); pulse_start(); spikes(4, 1);
        while (k < s + int'(WIN)) @(negedge clk);
        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
        wait_idle();

        for (int t = 0; t < 8; t++) begin
            cyc_n(int'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1)
                spikes(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            pulse_start();
            cyc_n(int'($urandom_range(0, 8)));
            spikes(int'($urandom_range(0, 17)), int'($urandom_range(0, 17)));
            wait_idle();
        end

        cyc_n(4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
